uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_tx_serializer.sv | 130 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: line-control field positions,
// word-length encodings, serializer FSM states and helpers.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned LCR_W              = 7;
    localparam int unsigned LCR_LATCH_W        = 6;

    localparam int unsigned LCR_WLS_LSB = 0;
    localparam int unsigned LCR_WLS_W   = 2;
    localparam int unsigned LCR_STB     = 2;
    localparam int unsigned LCR_PEN     = 3;
    localparam int unsigned LCR_EPS     = 4;
    localparam int unsigned LCR_STICK   = 5;
    localparam int unsigned LCR_BRK     = 6;

    localparam logic [LCR_WLS_W-1:0] WLS_5 = 2'b00;
    localparam logic [LCR_WLS_W-1:0] WLS_6 = 2'b01;
    localparam logic [LCR_WLS_W-1:0] WLS_7 = 2'b10;
    localparam logic [LCR_WLS_W-1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Index of the final data bit for a word-length code (4..7).
    function automatic logic [2:0] last_data_bit(input logic [LCR_WLS_W-1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

    // Mask selecting the data bits actually transmitted for a word-length code.
    function automatic logic [DATA_W-1:0] word_mask(input logic [LCR_WLS_W-1:0] wls);
        logic [DATA_W-1:0] m;
        case (wls)
            WLS_5:   m = 8'h1F;
            WLS_6:   m = 8'h3F;
            WLS_7:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops words from a TX FIFO and shifts out
// start / 5-8 data / optional parity / 1-2 stop bits on an oversampled tick.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic              tx_fifo_empty,
    input  logic [DATA_W-1:0] tx_fifo_data,
    input  logic [LCR_W-1:0]  lcr,
    output logic              tx_fifo_rd,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done_tick
);

    localparam int unsigned       TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    tx_state_e              state;
    logic [TICK_W-1:0]      tick_cnt;
    logic [2:0]             bit_cnt;
    logic [DATA_W-1:0]      data_q;
    logic [LCR_LATCH_W-1:0] lcr_q;
    logic                   line_bit;

    logic bit_end_c;
    logic last_data_c;
    logic last_stop_c;
    logic frame_end_c;
    logic load_c;
    logic par_bit_c;
    logic line_next_c;

    // Bit-boundary detection, frame reload decision and the next line level.
    always_comb begin
        bit_end_c   = s_tick && (tick_cnt == TICK_LAST);
        last_data_c = (bit_cnt == last_data_bit(lcr_q[LCR_WLS_LSB +: LCR_WLS_W]));
        last_stop_c = (bit_cnt == {2'b00, lcr_q[LCR_STB]});
        frame_end_c = (state == STOP) && bit_end_c && last_stop_c;
        load_c      = !tx_fifo_empty && ((state == IDLE) || frame_end_c);

        if (lcr_q[LCR_STICK]) begin
            par_bit_c = ~lcr_q[LCR_EPS];
        end else begin
            par_bit_c = (^(data_q & word_mask(lcr_q[LCR_WLS_LSB +: LCR_WLS_W])))
                        ^ ~lcr_q[LCR_EPS];
        end

        line_next_c = line_bit;
        if (load_c) begin
            line_next_c = 1'b0;
        end else if (bit_end_c) begin
            case (state)
                START:   line_next_c = data_q[0];
                DATA:    line_next_c = last_data_c ? (lcr_q[LCR_PEN] ? par_bit_c : 1'b1)
                                                   : data_q[bit_cnt + 3'd1];
                default: line_next_c = 1'b1;
            endcase
        end
    end

    // Frame sequencer; break overrides the line level without disturbing timing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            data_q       <= '0;
            lcr_q        <= '0;
            line_bit     <= 1'b1;
            tx           <= 1'b1;
            tx_fifo_rd   <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_fifo_rd   <= 1'b0;
            tx_done_tick <= frame_end_c;
            line_bit     <= line_next_c;
            tx           <= line_next_c & ~lcr[LCR_BRK];

            if ((state != IDLE) && s_tick) begin
                tick_cnt <= bit_end_c ? '0 : tick_cnt + TICK_W'(1);
            end

            if (load_c) begin
                state      <= START;
                tick_cnt   <= '0;
                bit_cnt    <= '0;
                data_q     <= tx_fifo_data;
                lcr_q      <= lcr[LCR_LATCH_W-1:0];
                tx_fifo_rd <= 1'b1;
                tx_busy    <= 1'b1;
            end else if (bit_end_c) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (last_data_c) begin
                            state   <= lcr_q[LCR_PEN] ? PARITY : STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        state   <= STOP;
                        bit_cnt <= '0;
                    end
                    STOP: begin
                        if (last_stop_c) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame formats, back-to-back words,
// break, mid-frame reset and a slowed baud tick, with a small FIFO model.
module tb_uart_tx_serializer;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b1;
    logic       slow   = 1'b0;
    logic [6:0] lcr    = 7'h03;
    logic       tx_fifo_empty;
    logic [7:0] tx_fifo_data;
    logic       tx_fifo_rd;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;

    logic [7:0] fq [16];
    int         head     = 0;
    int         tail     = 0;
    int         pops     = 0;
    int         done_cnt = 0;
    int         bad_rd   = 0;
    int         cyc      = 0;
    int         vecs     = 0;
    int         errs     = 0;

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_data (tx_fifo_data),
        .lcr          (lcr),
        .tx_fifo_rd   (tx_fifo_rd),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    assign tx_fifo_empty = (head == tail);
    assign tx_fifo_data  = fq[head[3:0]];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        s_tick <= slow ? ~s_tick : 1'b1;
        if (tx_done_tick) done_cnt <= done_cnt + 1;
        if (tx_fifo_rd) begin
            if (head == tail) bad_rd <= bad_rd + 1;
            head <= head + 1;
            pops <= pops + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fq[tail % 16] = d;
        tail++;
    endtask

    task automatic wait_start(input string tag, output int t0);
        bit found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        t0 = cyc;
        chk({tag, "_start_seen"}, 32'(found), 32'd1);
    endtask

    // seq holds the expected line levels in time order, first bit leftmost.
    task automatic check_frame(input string tag, input logic [11:0] seq, input int nbits,
                               input int per, input logic [6:0] lcr_after,
                               output int t0, output int el);
        bit found = 1'b0;
        wait_start(tag, t0);
        lcr = lcr_after;
        for (int i = 0; i < nbits; i++) begin
            repeat ((i == 0) ? per / 2 : per) @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(seq[nbits-1-i]));
        end
        for (int k = 0; k < per + 2; k++) begin
            if (tx_done_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(found), 32'd1);
        el = cyc - t0;
    endtask

    initial begin
        int t0, t1, el, pb, db;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rd", 32'(tx_fifo_rd), 32'd0);
        chk("rst_done", 32'(tx_done_tick), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);
        chk("idle_pops", 32'(pops), 32'd0);

        // 8N1, 0x55
        lcr = 7'h03;
        push(8'h55);
        check_frame("8n1_55", 12'b0101010101, 10, 16, 7'h03, t0, el);
        chk("8n1_55_len", 32'(el), 32'd160);
        chk("8n1_55_pops", 32'(pops), 32'd1);
        @(negedge clk);
        chk("8n1_55_done_cnt", 32'(done_cnt), 32'd1);
        chk("8n1_55_done_width", 32'(tx_done_tick), 32'd0);
        repeat (2) @(negedge clk);
        chk("8n1_55_idle_busy", 32'(tx_busy), 32'd0);
        chk("8n1_55_idle_tx", 32'(tx), 32'd1);

        // 7E1, 0x41; lcr rewritten mid-frame must not affect this frame
        lcr = 7'h1A;
        push(8'h41);
        check_frame("7e1_41", 12'b0100000101, 10, 16, 7'h03, t0, el);
        chk("7e1_41_len", 32'(el), 32'd160);
        repeat (3) @(negedge clk);

        // 7O1, 0xC1: bit 7 is outside the word and must not reach the line or parity
        lcr = 7'h0A;
        push(8'hC1);
        check_frame("7o1_c1", 12'b0100000111, 10, 16, 7'h0A, t0, el);
        chk("7o1_c1_len", 32'(el), 32'd160);
        repeat (3) @(negedge clk);

        // 5 data bits, stick parity (even -> 0), two stop bits
        lcr = 7'h3C;
        push(8'hFF);
        check_frame("5s2_ff", 12'b011111011, 9, 16, 7'h3C, t0, el);
        chk("5s2_ff_len", 32'(el), 32'd144);
        repeat (3) @(negedge clk);

        // Two queued words go out back to back
        lcr = 7'h03;
        pb = pops;
        db = done_cnt;
        push(8'hA5);
        push(8'h3C);
        check_frame("b2b_a5", 12'b0101001011, 10, 16, 7'h03, t0, el);
        chk("b2b_a5_busy", 32'(tx_busy), 32'd1);
        check_frame("b2b_3c", 12'b0001111001, 10, 16, 7'h03, t1, el);
        chk("b2b_gap", 32'(t1 - t0), 32'd160);
        @(negedge clk);
        chk("b2b_pops", 32'(pops - pb), 32'd2);
        chk("b2b_dones", 32'(done_cnt - db), 32'd2);
        repeat (3) @(negedge clk);

        // Break forces the line low next clock, then releases to the frame bit
        push(8'hFF);
        wait_start("brk", t0);
        repeat (8 + 16 * 3) @(negedge clk);
        chk("brk_pre", 32'(tx), 32'd1);
        lcr = 7'h43;
        @(negedge clk);
        chk("brk_on", 32'(tx), 32'd0);
        repeat (3) @(negedge clk);
        chk("brk_hold", 32'(tx), 32'd0);
        lcr = 7'h03;
        @(negedge clk);
        chk("brk_off", 32'(tx), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (tx_done_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("brk_done", 32'(found), 32'd1);
        chk("brk_len", 32'(cyc - t0), 32'd160);
        repeat (3) @(negedge clk);

        // Reset during data bit 3 aborts the frame
        push(8'h00);
        wait_start("rst_mid", t0);
        repeat (8 + 16 * 4) @(negedge clk);
        pb = pops;
        db = done_cnt;
        reset = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        push(8'h5A);
        repeat (5) @(negedge clk);
        chk("rst_mid_no_pop", 32'(pops), 32'(pb));
        chk("rst_mid_no_done", 32'(done_cnt), 32'(db));
        chk("rst_mid_rd", 32'(tx_fifo_rd), 32'd0);
        reset = 1'b0;
        check_frame("rst_mid_5a", 12'b0010110101, 10, 16, 7'h03, t0, el);
        chk("rst_mid_len", 32'(el), 32'd160);
        @(negedge clk);
        chk("rst_mid_pops", 32'(pops - pb), 32'd1);
        chk("rst_mid_dones", 32'(done_cnt - db), 32'd1);
        repeat (3) @(negedge clk);

        // Tick every other clock doubles each bit time
        slow = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h96);
        check_frame("slow_96", 12'b0011010011, 10, 32, 7'h03, t0, el);
        chk("slow_len", 32'((el >= 319) && (el <= 320)), 32'd1);
        slow = 1'b0;
        repeat (4) @(negedge clk);

        chk("rd_while_empty", 32'(bad_rd), 32'd0);
        chk("final_idle_busy", 32'(tx_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
